// File: rtl/dmem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access path: RV32I width codes,
// controller states and the byte-lane helper functions.
package dmem_access_ctrl_pkg;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] wdata;
    } req_t;

    // funct3[1:0] is the access size (B/H/W); funct3[2] selects unsigned loads.
    function automatic logic access_err(input logic we, input logic [2:0] f3,
                                        input logic [1:0] off);
        logic illegal;
        logic misalign;
        illegal  = (f3 == 3'b011) || (f3[2:1] == 2'b11) || (we && f3[2]);
        misalign = ((f3[1:0] == 2'b01) && off[0]) ||
                   ((f3[1:0] == 2'b10) && (off != 2'b00));
        return illegal || misalign;
    endfunction

    function automatic logic [NUM_LANES-1:0] byte_mask(input logic [2:0] f3,
                                                       input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << {off[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3,
                                               input logic [31:0] wd);
        case (f3[1:0])
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_extract.sv
// Aligns the assembled bank word to the addressed byte and applies the
// RV32I load width and sign/zero extension.
module dmem_load_extract
    import dmem_access_ctrl_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  boff,
    input  logic [31:0] word,
    output logic [31:0] result
);

    logic [31:0] s;

    always_comb begin
        s = word >> {boff, 3'b000};
        case (funct3)
            F3_B:    result = {{24{s[7]}}, s[7:0]};
            F3_BU:   result = {24'h0, s[7:0]};
            F3_H:    result = {{16{s[15]}}, s[15:0]};
            F3_HU:   result = {16'h0, s[15:0]};
            default: result = s;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Single-outstanding load/store sequencer onto four byte-wide data banks.
// Bank outputs depend only on state and latched request fields.
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [31:0]       rsp_rdata,
    output logic [ADDR_W-3:0] bank_addr,
    output logic [3:0]        bank_en,
    output logic [3:0]        bank_we,
    output logic [31:0]       bank_wdata,
    input  logic [31:0]       bank_rdata
);

    localparam int CNT_W = 2;

    state_e            state, state_nxt;
    req_t              req_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              accept;
    logic              req_err;
    logic [3:0]        mask;
    logic [31:0]       ld_word;

    assign accept  = req_valid && (state == ST_IDLE);
    assign req_err = access_err(req_we, req_funct3, req_addr[1:0]);
    assign mask    = byte_mask(req_q.funct3, addr_q[1:0]);

    dmem_load_extract u_extract (
        .funct3 (req_q.funct3),
        .boff   (addr_q[1:0]),
        .word   (bank_rdata),
        .result (ld_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        bank_en    = 4'b0000;
        bank_we    = 4'b0000;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (accept)
                    state_nxt = req_err ? ST_RESP : ST_ACCESS;
            end
            ST_ACCESS: begin
                if (req_q.we) begin
                    bank_en   = mask;
                    bank_we   = mask;
                    state_nxt = ST_RESP;
                end else begin
                    bank_en   = 4'b1111;
                    cnt_nxt   = CNT_W'(RD_LAT - 1);
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt == '0)
                    state_nxt = ST_RESP;
                else
                    cnt_nxt = cnt - 1'b1;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Response fields are cleared on accept so stores and errors report zero data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q     <= '0;
            addr_q    <= '0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            if (accept) begin
                req_q     <= '{we: req_we, funct3: req_funct3, wdata: req_wdata};
                addr_q    <= req_addr;
                rsp_err   <= req_err;
                rsp_rdata <= '0;
            end
            if ((state == ST_WAIT) && (cnt == '0))
                rsp_rdata <= ld_word;
        end
    end

    assign bank_addr  = addr_q[ADDR_W-1:2];
    assign bank_wdata = store_data(req_q.funct3, req_q.wdata);

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Randomized bench for dmem_access_ctrl: two instances (RD_LAT 1 and 3) with
// byte-bank RAM models, checked against a byte-array reference memory.
module tb_dmem_access_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic mem_clr;
    always #5 clk = ~clk;

    logic [1:0]        req_valid, req_ready, rsp_valid, rsp_err;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [11:0]       req_addr;
    logic [31:0]       req_wdata;
    logic [1:0][31:0]  rsp_rdata, bank_wdata, bank_rdata;
    logic [1:0][9:0]   bank_addr;
    logic [1:0][3:0]   bank_en, bank_we;

    logic [7:0] ref_mem [2][4096];
    int n_cmp = 0;
    int n_mis = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [31:0] bmem [0:1023];
        logic [31:0] pipe [0:3];

        dmem_access_ctrl #(.ADDR_W(12), .RD_LAT(LAT)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_we     (req_we),
            .req_funct3 (req_funct3),
            .req_addr   (req_addr),
            .req_wdata  (req_wdata),
            .rsp_valid  (rsp_valid[g]),
            .rsp_err    (rsp_err[g]),
            .rsp_rdata  (rsp_rdata[g]),
            .bank_addr  (bank_addr[g]),
            .bank_en    (bank_en[g]),
            .bank_we    (bank_we[g]),
            .bank_wdata (bank_wdata[g]),
            .bank_rdata (bank_rdata[g])
        );

        // Byte-bank RAM with a fixed read pipeline of LAT cycles.
        always @(posedge clk) begin
            if (mem_clr) begin
                for (int w = 0; w < 1024; w++) bmem[w] <= 32'h0;
            end else begin
                for (int l = 0; l < 4; l++)
                    if (bank_en[g][l] && bank_we[g][l])
                        bmem[bank_addr[g]][8*l +: 8] <= bank_wdata[g][8*l +: 8];
            end
            pipe[0] <= bmem[bank_addr[g]];
            for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
        end
        assign bank_rdata[g] = pipe[LAT-1];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic int rd_lat(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic ref_err(input logic we, input logic [2:0] f3, input logic [11:0] a);
        logic legal;
        legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal) return 1'b1;
        return (int'(a) % nbytes(f3)) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input int i, input logic [2:0] f3, input logic [11:0] a);
        logic [31:0] v;
        int sz;
        sz = nbytes(f3);
        v = 32'h0;
        for (int b = 0; b < sz; b++) v |= 32'(ref_mem[i][int'(a) + b]) << (8 * b);
        if (!f3[2] && sz < 4 && v[8*sz-1]) v |= ~((32'd1 << (8 * sz)) - 32'd1);
        return v;
    endfunction

    task automatic do_req(input int i, input logic we, input logic [2:0] f3,
                          input logic [11:0] a, input logic [31:0] wd, output logic [31:0] got);
        logic        e;
        int          n, k, sz;
        logic [3:0]  c1_en, c1_we, en_seen, emask;
        logic [9:0]  c1_addr;
        logic [31:0] c1_wd, exp_wd, exp_rd;
        e  = ref_err(we, f3, a);
        sz = nbytes(f3);
        @(negedge clk);
        req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        req_valid[i] = 1'b1;
        k = 0;
        while (!req_ready[i] && k < 20) begin @(negedge clk); k++; end
        if (k == 20) chk("ready_timeout", 32'(req_ready[i]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid[i] = 1'b0;
        n = 1;
        c1_en = bank_en[i]; c1_we = bank_we[i]; c1_addr = bank_addr[i]; c1_wd = bank_wdata[i];
        en_seen = 4'b0;
        while (!rsp_valid[i] && n < 20) begin
            en_seen |= bank_en[i];
            @(negedge clk);
            n++;
        end
        en_seen |= bank_en[i];
        chk("latency", 32'(n), e ? 32'd1 : (we ? 32'd2 : 32'(2 + rd_lat(i))));
        chk("rsp_err", 32'(rsp_err[i]), 32'(e));
        exp_rd = (e || we) ? 32'h0 : ref_load(i, f3, a);
        chk("rsp_rdata", rsp_rdata[i], exp_rd);
        got = rsp_rdata[i];
        if (e) begin
            chk("err_bank_en", 32'(en_seen), 32'h0);
        end else begin
            emask = 4'(((1 << sz) - 1) << a[1:0]);
            chk("c1_bank_en", 32'(c1_en), we ? 32'(emask) : 32'hf);
            chk("c1_bank_we", 32'(c1_we), we ? 32'(emask) : 32'h0);
            chk("c1_bank_addr", 32'(c1_addr), 32'(a >> 2));
            if (we) begin
                for (int l = 0; l < 4; l++) exp_wd[8*l +: 8] = wd[8*(l % sz) +: 8];
                chk("c1_bank_wdata", c1_wd, exp_wd);
                for (int b = 0; b < sz; b++) ref_mem[i][int'(a) + b] = wd[8*b +: 8];
            end
        end
        @(negedge clk);
        chk("rsp_one_cycle", 32'(rsp_valid[i]), 32'h0);
        chk("idle_ready", 32'(req_ready[i]), 32'h1);
    endtask

    logic [31:0] r;
    int          n, seen;

    initial begin
        for (int i = 0; i < 2; i++) for (int b = 0; b < 4096; b++) ref_mem[i][b] = 8'h0;
        req_valid = 2'b00; req_we = 1'b0; req_funct3 = 3'b0; req_addr = 12'h0; req_wdata = 32'h0;
        mem_clr = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        mem_clr = 1'b0;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h3);
        chk("rst_bank_en", 32'({bank_en[1], bank_en[0]}), 32'h0);
        chk("rst_bank_we", 32'({bank_we[1], bank_we[0]}), 32'h0);
        chk("rst_bank_addr", 32'(bank_addr[0]), 32'h0);
        chk("rst_bank_wdata", bank_wdata[0], 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'h0);
        chk("rst_rsp_rdata", rsp_rdata[0], 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 2; i++) begin
            do_req(i, 1'b1, 3'b010, 12'h010, 32'hDEADBEEF, r);
            do_req(i, 1'b1, 3'b000, 12'h013, 32'h000000A5, r);
            do_req(i, 1'b0, 3'b000, 12'h013, 32'h0, r);
            chk("lb_a5", r, 32'hFFFFFFA5);
            do_req(i, 1'b0, 3'b100, 12'h013, 32'h0, r);
            chk("lbu_a5", r, 32'h000000A5);
            do_req(i, 1'b1, 3'b010, 12'h010, 32'h80017FFF, r);
            do_req(i, 1'b0, 3'b001, 12'h012, 32'h0, r);
            chk("lh_8001", r, 32'hFFFF8001);
            do_req(i, 1'b0, 3'b101, 12'h012, 32'h0, r);
            chk("lhu_8001", r, 32'h00008001);
            do_req(i, 1'b0, 3'b010, 12'h002, 32'h0, r);
            do_req(i, 1'b1, 3'b001, 12'h001, 32'h1234, r);
            do_req(i, 1'b1, 3'b100, 12'h000, 32'h55, r);
        end

        // Reset while the RD_LAT=3 instance sits in its wait phase.
        @(negedge clk);
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 12'h010;
        req_valid[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_bank_en", 32'(bank_en[1]), 32'h0);
        chk("midrst_rsp_valid", 32'(rsp_valid[1]), 32'h0);
        chk("midrst_req_ready", 32'(req_ready[1]), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin @(negedge clk); if (rsp_valid[1] || bank_en[1] != 4'h0) seen++; end
        chk("midrst_no_activity", 32'(seen), 32'h0);

        // Back-to-back loads with req_valid held high.
        @(negedge clk);
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 12'h010;
        req_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n = 1; seen = 0;
        while (!rsp_valid[0] && n < 20) begin
            if (req_ready[0]) seen++;
            @(negedge clk);
            n++;
        end
        if (req_ready[0]) seen++;
        chk("b2b_first_rdata", rsp_rdata[0], ref_load(0, 3'b010, 12'h010));
        chk("b2b_ready_low", 32'(seen), 32'h0);
        req_funct3 = 3'b100; req_addr = 12'h013;
        @(negedge clk);
        chk("b2b_ready_after_resp", 32'(req_ready[0]), 32'h1);
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        n = 1;
        while (!rsp_valid[0] && n < 20) begin @(negedge clk); n++; end
        chk("b2b_second_lat", 32'(n), 32'd3);
        chk("b2b_second_rdata", rsp_rdata[0], ref_load(0, 3'b100, 12'h013));
        @(negedge clk);

        for (int t = 0; t < 300; t++) begin
            int          i;
            logic        we;
            logic [2:0]  f3;
            logic [11:0] a;
            i  = int'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 63));
            do_req(i, we, f3, a, $urandom, r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
